// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock sequencer: FSM state encoding and counter sizing helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PWR_UP = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    RETRY  = 3'd4,
    FAULT  = 3'd5
  } pll_state_e;

  localparam int unsigned LOSS_CNT_W = 8;

  // Width for a counter holding 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock pin into the clk_in domain.
module pll_lock_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: power-up, lock settle, run, retry and fault handling on clk_in.
// Optional RUN->RETRY loss counter enabled by defining PLL_SEQ_LOSS_COUNT_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned OFF_CYCLES    = 16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       start,
  input  logic       pll_lock,
  output logic       pll_en,
  output logic       rst_out,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
`ifdef PLL_SEQ_LOSS_COUNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] loss_count
`endif
);

  localparam int unsigned TW = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned SW = cnt_width(STABLE_CYCLES);
  localparam int unsigned OW = cnt_width(OFF_CYCLES);
  localparam int unsigned RW = cnt_width(MAX_RETRIES + 1);

  localparam logic [TW-1:0] TIMER_MAX  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [OW-1:0] OFF_MAX    = OW'(OFF_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  logic lock_s;

  pll_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [OW-1:0] off_q, off_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          pll_en_q, pll_en_d;
  logic          rst_out_q, rst_out_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;

  pll_lock_sync u_sync (
    .clk_in   (clk_in),
    .reset    (reset),
    .async_in (pll_lock),
    .sync_out (lock_s)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      stable_q  <= '0;
      off_q     <= '0;
      retry_q   <= '0;
      pll_en_q  <= 1'b0;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      stable_q  <= stable_d;
      off_q     <= off_d;
      retry_q   <= retry_d;
      pll_en_q  <= pll_en_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  // Per-state counters default to zero so every state is entered with a fresh count.
  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    stable_d = '0;
    off_d    = '0;
    retry_d  = retry_q;
    if (!start && (state_q != FAULT)) begin
      state_d = IDLE;
      retry_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = PWR_UP;
        end
        PWR_UP: begin
          if (lock_s) begin
            state_d = SETTLE;
          end else if (timer_q == TIMER_MAX) begin
            state_d = (retry_q < RETRY_MAX) ? RETRY : FAULT;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state_d = PWR_UP;
          end else if (stable_q == STABLE_MAX) begin
            state_d = RUN;
            retry_d = '0;
          end else begin
            stable_d = stable_q + SW'(1);
          end
        end
        RUN: begin
          if (!lock_s) state_d = RETRY;
        end
        RETRY: begin
          if (off_q == OFF_MAX) begin
            state_d = PWR_UP;
            if (retry_q != RETRY_MAX) retry_d = retry_q + RW'(1);
          end else begin
            off_d = off_q + OW'(1);
          end
        end
        FAULT: begin
          if (!start) begin
            state_d = IDLE;
            retry_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode the state being entered so the registered value tracks state_q exactly.
  always_comb begin
    pll_en_d  = (state_d == PWR_UP) || (state_d == SETTLE) || (state_d == RUN);
    rst_out_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  assign pll_en  = pll_en_q;
  assign rst_out = rst_out_q;
  assign ready   = ready_q;
  assign fault   = fault_q;
  assign state   = state_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if ((state_q == RUN) && (state_d == RETRY) && (loss_q != '1)) begin
      loss_d = loss_q + LOSS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) loss_q <= '0;
    else       loss_q <= loss_d;
  end

  assign loss_count = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: per-cycle expected outputs queued ahead of time, compared at negedge.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       start;
  logic       pll_lock;
  logic       pll_en;
  logic       rst_out;
  logic       ready;
  logic       fault;
  logic [2:0] state;
`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] loss_count;
`endif

  pll_lock_sequencer #(
    .LOCK_TIMEOUT  (64),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .OFF_CYCLES    (16)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .start    (start),
    .pll_lock (pll_lock),
    .pll_en   (pll_en),
    .rst_out  (rst_out),
    .ready    (ready),
    .fault    (fault),
    .state    (state)
`ifdef PLL_SEQ_LOSS_COUNT_EN
    ,
    .loss_count (loss_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         cyc;
    logic [6:0] v;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // {state, pll_en, rst_out, ready, fault} expected while sitting in st
  function automatic logic [6:0] exp_vec(input pll_state_e st);
    logic en, ro, rdy, flt;
    en  = (st == PWR_UP) || (st == SETTLE) || (st == RUN);
    ro  = (st != RUN);
    rdy = (st == RUN);
    flt = (st == FAULT);
    return {3'(st), en, ro, rdy, flt};
  endfunction

  task automatic push_span(input int from, input int to, input pll_state_e st, input string tag);
    for (int c = from; c <= to; c++) sbq.push_back('{cyc: c, v: exp_vec(st), tag: tag});
  endtask

  // Three 64-cycle power-up windows, two 16-cycle off gaps, then FAULT.
  task automatic push_never_lock(input int b, input string tag);
    push_span(b + 1,   b + 64,  PWR_UP, tag);
    push_span(b + 65,  b + 80,  RETRY,  tag);
    push_span(b + 81,  b + 144, PWR_UP, tag);
    push_span(b + 145, b + 160, RETRY,  tag);
    push_span(b + 161, b + 224, PWR_UP, tag);
    push_span(b + 225, b + 230, FAULT,  tag);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  always @(negedge clk_in) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      logic [6:0] obs;
      mon_e = sbq.pop_front();
      obs   = {state, pll_en, rst_out, ready, fault};
      checks++;
      assert (mon_e.cyc == cyc && obs === mon_e.v) else begin
        failures++;
        $error("FAIL %s cyc=%0d want_cyc=%0d observed=%b expected=%b",
               mon_e.tag, cyc, mon_e.cyc, obs, mon_e.v);
      end
    end
  end

  initial begin
    int t, l, x, g0, f, h, n, m;
    reset = 1'b1; start = 1'b0; pll_lock = 1'b0;
    tick(3);
    reset = 1'b0;
    t = cyc;
    push_span(t, t + 2, IDLE, "reset_idle");
    tick(3);

    // Nominal bring-up: lock 20 cycles after start, RUN 11 cycles after the lock drive.
    t = cyc;
    l = t + 20;
    start = 1'b1;
    push_span(t + 1,  l + 2,  PWR_UP, "nom_pwrup");
    push_span(l + 3,  l + 10, SETTLE, "nom_settle");
    push_span(l + 11, l + 14, RUN,    "nom_run");
    tick(20);
    pll_lock = 1'b1;
    tick(14);

    // start dropped in RUN
    x = cyc;
    start = 1'b0; pll_lock = 1'b0;
    push_span(x + 1, x + 2, IDLE, "stop_run");
    tick(2);

    // One-cycle lock glitch at settle count 5
    g0 = cyc;
    start = 1'b1; pll_lock = 1'b1;
    push_span(g0 + 1,  g0 + 2,  PWR_UP, "gl_pwrup");
    push_span(g0 + 3,  g0 + 8,  SETTLE, "gl_settle1");
    push_span(g0 + 9,  g0 + 9,  PWR_UP, "gl_back");
    push_span(g0 + 10, g0 + 17, SETTLE, "gl_settle2");
    push_span(g0 + 18, g0 + 22, RUN,    "gl_run");
    tick(6);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(15);

    // Lock lost in RUN, relock during RETRY
    f = cyc;
    pll_lock = 1'b0;
    push_span(f + 1,  f + 2,  RUN,    "loss_run");
    push_span(f + 3,  f + 18, RETRY,  "loss_retry");
    push_span(f + 19, f + 19, PWR_UP, "loss_pwrup");
    push_span(f + 20, f + 27, SETTLE, "loss_settle");
    push_span(f + 28, f + 30, RUN,    "loss_rerun");
    tick(10);
    pll_lock = 1'b1;
    tick(20);
`ifdef PLL_SEQ_LOSS_COUNT_EN
    checks++;
    assert (loss_count === 8'd1) else begin
      failures++;
      $error("FAIL loss_count observed=%0d expected=1", loss_count);
    end
`endif

    // Reset mid-SETTLE, then reset mid-RUN
    h = cyc;
    start = 1'b0;
    push_span(h + 1, h + 1, IDLE, "rs_idle");
    tick(1);
    start = 1'b1;
    push_span(h + 2, h + 2, PWR_UP, "rs_pwrup");
    push_span(h + 3, h + 5, SETTLE, "rs_settle");
    push_span(h + 6, h + 6, IDLE,   "rs_reset_settle");
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    push_span(h + 7,  h + 8,  PWR_UP, "rs_pwrup2");
    push_span(h + 9,  h + 16, SETTLE, "rs_settle2");
    push_span(h + 17, h + 18, RUN,    "rs_run");
    tick(12);
    reset = 1'b1;
    push_span(h + 19, h + 19, IDLE, "rs_reset_run");
    tick(1);
    reset = 1'b0; start = 1'b0; pll_lock = 1'b0;
    push_span(h + 20, h + 21, IDLE, "rs_idle2");
    tick(2);

    // Never lock: retries exhausted into FAULT
    n = cyc;
    start = 1'b1;
    push_never_lock(n, "nolock");
    tick(230);

    // Leave FAULT for one cycle; a full fresh retry budget must follow
    m = cyc;
    start = 1'b0;
    push_span(m + 1, m + 1, IDLE, "fault_exit");
    tick(1);
    start = 1'b1;
    push_never_lock(m + 1, "nolock2");
    tick(231);
    repeat (2) @(negedge clk_in);

    checks++;
    assert (sbq.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain observed=%0d expected=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 1024, meaning the number of clk_in cycles allowed in PWR_UP for lock to appear (legal range 4..65535).
REQ-002 SHALL have parameter STABLE_CYCLES, default 256, meaning the consecutive synchronised-lock cycles required before release (legal range 2..65535).
REQ-003 SHALL have parameter MAX_RETRIES, default 3, meaning the number of PLL power-cycle retries before FAULT (legal range 0..15).
REQ-004 SHALL have parameter OFF_CYCLES, default 16, meaning the number of cycles pll_en is held low in RETRY (legal range 1..255).
REQ-005 Port clk_in, input, 1: reference clock, pre-PLL (CLK_BUF output); all logic is on this clock.
REQ-006 Port reset, input, 1: reset; one clock; reset is synchronous and active-high.
REQ-007 Port start, input, 1: level request to bring up the PLL.
REQ-008 Port pll_lock, input, 1: PLL LOCK, asynchronous to clk_in.
REQ-009 Port pll_en, output, 1: drives PLL_EN.
REQ-010 Port rst_out, output, 1: active-high reset for the PLL-clocked domains (1 = hold).
REQ-011 Port ready, output, 1: PLL locked and stable; downstream domains released.
REQ-012 Port fault, output, 1: retries exhausted.
REQ-013 Port state, output, 3: current FSM state encoding, for debug.

Function
REQ-014 pll_lock SHALL pass through a 2-flop synchroniser (lock_s) before any use.
- Lock-assertion latency from pin to lock_s: 2 cycles.
REQ-015 FSM states SHALL be IDLE=0, PWR_UP=1, SETTLE=2, RUN=3, RETRY=4, FAULT=5.
REQ-016 IDLE SHALL transition as follows.
- pll_en=0, rst_out=1.
- start=1 -> PWR_UP; timer cleared.
REQ-017 PWR_UP SHALL transition as follows.
- pll_en=1.
- lock_s=1 -> SETTLE, stable counter cleared.
- Timer reaching LOCK_TIMEOUT-1 -> RETRY if retry_cnt<MAX_RETRIES, else FAULT.
- If lock_s=1 and the timeout occur in the same cycle, lock wins.
REQ-018 SETTLE SHALL transition as follows.
- Stable counter increments each cycle with lock_s=1.
- lock_s=0 -> PWR_UP; timer restarted; no retry consumed.
- Counter reaching STABLE_CYCLES-1 -> RUN.
REQ-019 RUN SHALL drive rst_out=0 and ready=1, and SHALL clear retry_cnt on entry.
- lock_s=0 -> RETRY.
REQ-020 RETRY SHALL drive pll_en=0 for OFF_CYCLES cycles, then go to PWR_UP with retry_cnt+1.
REQ-021 FAULT SHALL drive fault=1, pll_en=0, rst_out=1.
- Exit only on start=0 (-> IDLE, retry_cnt cleared) or on reset.
REQ-022 start=0 in any state other than FAULT SHALL force IDLE on the next edge; counters cleared.
REQ-023 All outputs SHALL be registered: each output reflects the state entered on the same edge, with no combinational path from any input.
REQ-024 rst_out SHALL be 1 in every state except RUN.
- ready SHALL equal ~rst_out.
REQ-025 Counters SHALL be sized by $clog2 of their parameter and SHALL saturate, never wrap.

Reset
REQ-026 On reset=1 at a clk_in edge, the block SHALL load state=IDLE, pll_en=0, rst_out=1, ready=0, fault=0, all counters=0, and synchroniser flops=0.
REQ-027 Reset asserted mid-RUN SHALL assert rst_out and deassert pll_en on that edge.

Configuration
REQ-028 With PLL_SEQ_LOSS_COUNT_EN defined, the block SHALL add port loss_count, output, 8: the count of RUN->RETRY transitions, saturating at 255 and cleared only by reset.
REQ-029 Without PLL_SEQ_LOSS_COUNT_EN, the loss_count port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-030 Package pll_seq_pkg SHALL hold the state enum typedef and the encodings from REQ-015.
REQ-031 The synchroniser SHALL be sub-module pll_lock_sync, a 2-flop synchroniser whose flops are reset by reset.

Verification
Parameters for all scenarios: LOCK_TIMEOUT=64, STABLE_CYCLES=8, MAX_RETRIES=2, OFF_CYCLES=16.
REQ-032 Nominal: start=1, pll_lock rises 20 cycles later -> ready=1 exactly 2+8+1 cycles after the lock edge; pll_en=1 throughout.
REQ-033 Glitch in SETTLE: lock drops for 1 cycle at settle count 5 -> return to PWR_UP, counter restarts, ready is delayed, no retry consumed.
REQ-034 Never lock: pll_lock=0 -> three 64-cycle PWR_UP windows separated by 16-cycle pll_en=0 gaps, then fault=1 with pll_en=0.
REQ-035 Loss in RUN: pll_lock falls -> rst_out=1 within 3 cycles; RETRY then relock; ready again; with PLL_SEQ_LOSS_COUNT_EN defined, loss_count=1.
REQ-036 Reset mid-SETTLE, and start=0 in RUN -> IDLE with rst_out=1 and pll_en=0 on the next edge.
REQ-037 In FAULT, start=0 for one cycle then start=1 -> new PWR_UP attempt with retry_cnt=0.
